// File: rtl/sr_latch_driver.sv
// Clocked S/R pulse driver for the gate-level SR latch: fixed-width pulses, guard gap, one pending slot.
// Define SR_LATCH_DRIVER_CHECK_EN to add the CHECK state and Q/NQ feedback fault detection.
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int GUARD_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic S,
    output logic R,
    output logic busy,
    output logic done,
    output logic state_exp,
    input  logic Q_fb,
    input  logic NQ_fb,
    output logic fault
);

    localparam int MAX_W = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GUARD = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic             r_pend_v;
    logic             r_pend_op;
    logic             r_s;
    logic             r_r;
    logic             r_busy;
    logic             r_done;
    logic             r_state_exp;
    logic             r_fault;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_op_nxt;
    logic             w_pend_v_nxt;
    logic             w_pend_op_nxt;
    logic             w_done_nxt;
    logic             w_state_exp_nxt;
    logic             w_fault_nxt;
    logic             w_req;
    logic             w_req_op;

    // Clear dominates a simultaneous set; op value 1 means set.
    assign w_req    = set_req | clr_req;
    assign w_req_op = ~clr_req;

    // Next-state, counter, pending slot and status computation.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_op_nxt        = r_op;
        w_pend_v_nxt    = r_pend_v;
        w_pend_op_nxt   = r_pend_op;
        w_done_nxt      = 1'b0;
        w_state_exp_nxt = r_state_exp;
        w_fault_nxt     = r_fault;

        if ((r_state != ST_IDLE) && w_req) begin
            w_pend_v_nxt  = 1'b1;
            w_pend_op_nxt = w_req_op;
        end else begin
            w_pend_v_nxt  = r_pend_v;
            w_pend_op_nxt = r_pend_op;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt  = ST_PULSE;
                    w_cnt_nxt    = PULSE_LOAD;
                    w_op_nxt     = w_req_op;
                    w_pend_v_nxt = 1'b0;
                end else if (r_pend_v) begin
                    w_state_nxt  = ST_PULSE;
                    w_cnt_nxt    = PULSE_LOAD;
                    w_op_nxt     = r_pend_op;
                    w_pend_v_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = GUARD_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_GUARD: begin
                if (r_cnt == CNT_ZERO) begin
`ifdef SR_LATCH_DRIVER_CHECK_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

`ifdef SR_LATCH_DRIVER_CHECK_EN
        w_done_nxt = (w_state_nxt == ST_CHECK);
        // state_exp was already updated on entry to CHECK, so it is the value to verify.
        if ((r_state == ST_CHECK) &&
            ((Q_fb != r_state_exp) || (NQ_fb != ~r_state_exp) || (Q_fb == NQ_fb))) begin
            w_fault_nxt = 1'b1;
        end else begin
            w_fault_nxt = r_fault;
        end
`else
        w_done_nxt  = (w_state_nxt == ST_GUARD) && (w_cnt_nxt == CNT_ZERO);
        w_fault_nxt = 1'b0;
`endif

        if (w_done_nxt) begin
            w_state_exp_nxt = w_op_nxt;
        end else begin
            w_state_exp_nxt = r_state_exp;
        end
    end

`ifndef SR_LATCH_DRIVER_CHECK_EN
    logic w_unused_fb;
    assign w_unused_fb = Q_fb ^ NQ_fb;
`endif

    // State and registered outputs; S and R derive from one op bit so they are never both high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_op        <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_op   <= 1'b0;
            r_s         <= 1'b0;
            r_r         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_state_exp <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_pend_v    <= w_pend_v_nxt;
            r_pend_op   <= w_pend_op_nxt;
            r_s         <= (w_state_nxt == ST_PULSE) & w_op_nxt;
            r_r         <= (w_state_nxt == ST_PULSE) & ~w_op_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_state_exp <= w_state_exp_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    assign S         = r_s;
    assign R         = r_r;
    assign busy      = r_busy;
    assign done      = r_done;
    assign state_exp = r_state_exp;
    assign fault     = r_fault;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: an operation-timeline model predicts every output cycle.
// Honours SR_LATCH_DRIVER_CHECK_EN when defined for the build.
module tb_sr_latch_driver;

    localparam int PW = 4;
    localparam int GW = 2;
`ifdef SR_LATCH_DRIVER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    // Cycles an operation keeps the driver busy; a new op may start D+1 edges after the last.
    localparam int D = PW + GW + (CHK ? 1 : 0);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic Q_fb = 1'b0;
    logic NQ_fb = 1'b1;
    logic S, R, busy, done, state_exp, fault;

    always #5 clk = ~clk;

    sr_latch_driver #(.PULSE_W(PW), .GUARD_W(GW)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .S(S), .R(R), .busy(busy), .done(done), .state_exp(state_exp),
        .Q_fb(Q_fb), .NQ_fb(NQ_fb), .fault(fault)
    );

    logic [5:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc_idx = 0;
    int n_done_exp = 0;
    int n_done_seen = 0;

    // Reference model state: timeline of the current operation plus one pending slot.
    int edge_no = 0;
    int op_start = -1;
    bit cur_op = 1'b0;
    bit pend_v = 1'b0;
    bit pend_op = 1'b0;
    bit m_exp = 1'b0;
    bit m_fault = 1'b0;
    bit lq = 1'b0;

    task automatic start_op(input bit op);
        op_start = edge_no;
        cur_op   = op;
        pend_v   = 1'b0;
    endtask

    task automatic step(input bit i_set, input bit i_clr, input bit i_rst, input bit i_bad);
        bit req, rop, es, er, eb, ed;
        int rel;
        @(negedge clk);
        if (S === 1'b1) lq = 1'b1;
        else if (R === 1'b1) lq = 1'b0;
        set_req = i_set;
        clr_req = i_clr;
        rst     = i_rst;
        if (CHK) begin
            Q_fb  = i_bad ? 1'b0 : lq;
            NQ_fb = i_bad ? 1'b0 : ~lq;
        end else begin
            Q_fb  = 1'($urandom);
            NQ_fb = 1'($urandom);
        end
        req = i_set | i_clr;
        rop = ~i_clr;
        if (i_rst) begin
            op_start = -1;
            pend_v   = 1'b0;
            m_exp    = 1'b0;
            m_fault  = 1'b0;
        end else if (op_start >= 0 && edge_no <= op_start + D) begin
            if (req) begin
                pend_v  = 1'b1;
                pend_op = rop;
            end
            if (CHK && edge_no == op_start + D) begin
                if (Q_fb !== cur_op || NQ_fb !== ~cur_op || Q_fb === NQ_fb) m_fault = 1'b1;
            end
        end else if (req) begin
            start_op(rop);
        end else if (pend_v) begin
            start_op(pend_op);
        end
        es = 1'b0; er = 1'b0; eb = 1'b0; ed = 1'b0;
        rel = (op_start >= 0) ? edge_no - op_start : D + 1;
        if (rel < D) begin
            eb = 1'b1;
            es = cur_op && rel < PW;
            er = !cur_op && rel < PW;
            if (rel == D - 1) begin
                ed    = 1'b1;
                m_exp = cur_op;
                n_done_exp++;
            end
        end
        exp_q.push_back({es, er, eb, ed, m_exp, m_fault});
        edge_no++;
    endtask

    // Monitor: pops one expectation per clock edge and compares all outputs.
    always begin
        logic [5:0] x, got;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            got = {S, R, busy, done, state_exp, fault};
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL outputs cycle %0d got %b exp %b (S R busy done state_exp fault)",
                         cyc_idx, got, x);
            end
            checks++;
            if ((S & R) !== 1'b0) begin
                errors++;
                $display("FAIL s_and_r cycle %0d S=%b R=%b required not both 1", cyc_idx, S, R);
            end
            if (done === 1'b1) n_done_seen++;
            cyc_idx++;
        end
    end

    initial begin
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        // Single set operation
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Simultaneous set and clear: clear wins
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Pending overwrite during a set pulse
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Bad feedback (Q=NQ=0) on a set, then correct ops; fault must stick
        step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (D + 2) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (D + 2) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (D + 2) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        // Reset during the second pulse cycle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 4);
        end
        repeat (D + 3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (n_done_seen != n_done_exp) begin
            errors++;
            $display("FAIL done_count got %0d exp %0d", n_done_seen, n_done_exp);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d left exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
